ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Initiator for the single-port block RAM port (address/din/we/oe, one-cycle registered read data).
- On start, it reads `count` consecutive words beginning at `base` and presents them as a valid/ready stream.
- Addresses wrap at the RAM's reported length.
- An internal 2-entry buffer absorbs the RAM read latency so the stream sink may stall on any cycle without data loss.

Parameters:
- WIDTH, 32, data word width; must match the attached RAM.
- DEPTH, 10, RAM address bits actually decoded; address output is zero-extended to 32 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- base  in  32  first word address, captured on accepted start
- count  in  32  number of words to read, captured on accepted start
- ram_length  in  32  word count reported by the RAM's length output
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of transfer
- err  out  1  one-cycle pulse together with done when base >= ram_length
- ram_address  out  32  RAM address
- ram_din  out  WIDTH  constant 0
- ram_we  out  1  constant 0
- ram_oe  out  1  high in each cycle a read is issued
- ram_dout  in  WIDTH  RAM registered read data
- m_data  out  WIDTH  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  sink ready; a beat transfers when m_valid and m_ready

Behaviour:
- Reset (reset low, asynchronous) clears all state. Outputs: busy=0, done=0, err=0, ram_address=0, ram_oe=0, m_valid=0, m_data=0. State goes to IDLE.
- The same clearing applies when reset asserts mid-transfer. Read data returning afterwards is discarded.
- States are IDLE, RUN, DRAIN, FIN.
- IDLE, start=1 with base >= ram_length: go to FIN with err set. No reads are issued.
- IDLE, start=1 with count=0: go to FIN. No reads are issued.
- IDLE, start=1 otherwise: latch addr=base and remaining=count; set busy=1; go to RUN.
- RUN issues a read when remaining>0 and (buf_count + inflight - pop) < 2.
  - pop = m_valid & m_ready in the same cycle.
  - Issuing sets ram_oe=1 and ram_address=addr, both combinational from the registered addr.
  - On issue: addr <= (addr+1 == ram_length) ? 0 : addr+1; remaining decrements.
- Read latency: ram_dout is captured into the buffer exactly one cycle after an issue cycle (inflight flag, 1 bit).
- Buffer: 2-entry FIFO with m_data/m_valid driven from its head.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - A push into a full buffer cannot occur by construction. The bench asserts this.
- RUN goes to DRAIN when the last read is issued (remaining reaches 0).
- DRAIN goes to FIN when inflight=0, the buffer is empty, and no push is pending.
- FIN: done=1 (and err if flagged) for one cycle; busy drops in the same cycle; go to IDLE.
- Streaming rate: with m_ready held high, one word is delivered per cycle. The first m_valid rises 2 cycles after accepted start (cycle 1 issue, cycle 2 data registered).
- start outside IDLE is ignored. base, count and ram_length are sampled only at start acceptance.
- Words are emitted strictly in address order; no word is duplicated or dropped under any m_ready pattern.

Decomposition:
- Shared package: state enumeration (IDLE/RUN/DRAIN/FIN) and buffer depth constant 2.
- One sub-module is natural: ram_stream_skid_fifo, the 2-entry push/pop buffer with count, parameterised by WIDTH.

Test Plan:
- RAM filled with mem[i]=i+100, WORDS=1024; start base=5, count=4, m_ready=1 → m_data 105,106,107,108 on consecutive cycles; first valid 2 cycles after start; done one cycle after last beat.
- Same transfer with m_ready toggling 1,0,0,1,0,1... → same 4 words in order; no drops or duplicates; ram_oe never issues past 2 outstanding.
- base=1022, count=4, ram_length=1024 → addresses 1022,1023,0,1; data 1122,1123,100,101.
- count=0 → done pulse, no ram_oe, no m_valid. base=2000, ram_length=1024 → done and err pulse together, no reads.
- reset driven low during RUN with 1 word buffered → m_valid, busy and ram_oe are 0 immediately; after release, a new start (base=0, count=2) yields 100,101 only.
- start pulsed while busy → ignored; the transfer in progress completes unchanged; ram_we=0 throughout all tests.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader_pkg
// Description : Shared state encoding and buffer sizing for the RAM stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int c_BUF_DEPTH = 2;
    localparam int c_BUF_CNT_W = $clog2(c_BUF_DEPTH + 1);
    localparam int c_BUF_PTR_W = $clog2(c_BUF_DEPTH);

endpackage
`default_nettype wire

// File: rtl/ram_stream_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_skid_fifo
// Description : Two-entry push/pop buffer; head entry drives the stream output.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_skid_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_data,
    output logic                   o_head_valid,
    output logic [c_BUF_CNT_W-1:0] o_count
);

    logic [WIDTH-1:0]       r_mem [0:c_BUF_DEPTH-1];
    logic [c_BUF_PTR_W-1:0] r_wr_ptr;
    logic [c_BUF_PTR_W-1:0] r_rd_ptr;
    logic [c_BUF_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_BUF_CNT_W'(1);
                2'b01:   r_count <= r_count - c_BUF_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data  = r_mem[r_rd_ptr];
    assign o_head_valid = (r_count != '0);
    assign o_count      = r_count;

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader
// Description : Reads a wrapping range of block-RAM words and streams them out.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [31:0]      count,
    input  logic [31:0]      ram_length,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      ram_address,
    output logic [WIDTH-1:0] ram_din,
    output logic             ram_we,
    output logic             ram_oe,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    localparam int c_OCC_W = c_BUF_CNT_W + 1;

    state_t                 r_state;
    logic [31:0]            r_addr;
    logic [31:0]            r_len;
    logic [31:0]            r_remaining;
    logic                   r_inflight;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic                   w_pop;
    logic                   w_issue;
    logic                   w_drained;
    logic [31:0]            w_addr_inc;
    logic [c_BUF_CNT_W-1:0] w_buf_count;
    logic [c_BUF_CNT_W-1:0] w_left_after_pop;
    logic [c_OCC_W-1:0]     w_occupancy;

    ram_stream_skid_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk          (clk),
        .i_rst_n      (reset),
        .i_push       (r_inflight),
        .i_push_data  (ram_dout),
        .i_pop        (w_pop),
        .o_head_data  (m_data),
        .o_head_valid (m_valid),
        .o_count      (w_buf_count)
    );

    assign w_pop = m_valid & m_ready;

    // Words already committed to the buffer after this cycle's pop, including the read in flight.
    assign w_occupancy      = {1'b0, w_buf_count} + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_issue          = (r_state == ST_RUN) && (r_remaining != 32'd0)
                              && (w_occupancy < c_OCC_W'(c_BUF_DEPTH));
    assign w_left_after_pop = w_buf_count - c_BUF_CNT_W'(w_pop);
    assign w_drained        = !r_inflight && (w_left_after_pop == '0);
    assign w_addr_inc       = r_addr + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_inflight <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (base >= ram_length) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (count == 32'd0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr      <= base;
                            r_len       <= ram_length;
                            r_remaining <= count;
                            r_busy      <= 1'b1;
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_addr      <= (w_addr_inc == r_len) ? 32'd0 : w_addr_inc;
                        r_remaining <= r_remaining - 32'd1;
                        if (r_remaining == 32'd1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign ram_oe      = w_issue;
    assign ram_address = w_issue ? 32'(r_addr[DEPTH-1:0]) : 32'd0;
    assign ram_din     = '0;
    assign ram_we      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_stream_reader
// Description : Directed bench with a queue-based reference model of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;
    localparam int WORDS = 1024;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base = '0;
    logic [31:0]      count = '0;
    logic [31:0]      ram_length = 32'(WORDS);
    logic             busy, done, err;
    logic [31:0]      ram_address;
    logic [WIDTH-1:0] ram_din;
    logic             ram_we, ram_oe;
    logic [WIDTH-1:0] ram_dout = '0;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;

    ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .ram_length(ram_length), .busy(busy), .done(done), .err(err),
        .ram_address(ram_address), .ram_din(ram_din), .ram_we(ram_we),
        .ram_oe(ram_oe), .ram_dout(ram_dout), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [0:WORDS-1];
    initial for (int i = 0; i < WORDS; i++) mem[i] = WIDTH'(i + 100);
    always @(posedge clk) if (ram_oe) ram_dout <= mem[ram_address[DEPTH-1:0]];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Reference model: expected reads/words per transfer, plus logs of what the DUT did.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_err;
    int          outstanding;
    bit          expect_accept;
    int          cyc, start_cyc, done_cyc, done_cnt, oe_cnt, valid_cnt;
    bit          done_err;
    int          beat_cyc_q[$];
    logic [31:0] beat_data_q[$];
    logic [31:0] addr_log_q[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (expect_accept && start) begin
                start_cyc     = cyc;
                expect_accept = 1'b0;
            end
            check("ram_we", ram_we, 0);
            if (ram_oe) begin
                oe_cnt++;
                addr_log_q.push_back(ram_address);
                if (exp_addr_q.size() == 0) fail("unexpected_read");
                else check("ram_address", ram_address, exp_addr_q.pop_front());
            end
            if (m_valid) valid_cnt++;
            if (m_valid && m_ready) begin
                beat_cyc_q.push_back(cyc);
                beat_data_q.push_back(m_data);
                if (exp_data_q.size() == 0) fail("unexpected_beat");
                else check("m_data", m_data, exp_data_q.pop_front());
            end
            outstanding += int'(ram_oe) - int'(m_valid && m_ready);
            if (ram_oe) check("outstanding_le_2", outstanding <= 2, 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = err;
                check("err_with_done", err, exp_err);
                check("words_left_at_done", exp_data_q.size(), 0);
                check("busy_at_done", busy, 0);
            end else if (err) begin
                fail("err_without_done");
            end
            if (dut.u_fifo.i_push) check("push_into_full", dut.u_fifo.o_count == 2'd2, 0);
        end
    end

    int       ready_mode = 0;
    bit [5:0] ready_pat = 6'b101001;
    initial begin
        int pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ready_pat[pidx % 6];
                default: m_ready = 1'b0;
            endcase
            pidx++;
        end
    end

    task automatic clear_logs();
        beat_cyc_q.delete();
        beat_data_q.delete();
        addr_log_q.delete();
        done_cnt  = 0;
        oe_cnt    = 0;
        valid_cnt = 0;
        done_err  = 1'b0;
    endtask

    task automatic begin_xfer(input logic [31:0] b, input logic [31:0] c, input logic [31:0] len);
        logic [31:0] a;
        exp_err = (b >= len);
        if (!exp_err) begin
            for (longint k = 0; k < longint'(c); k++) begin
                a = 32'((longint'(b) + k) % longint'(len));
                exp_addr_q.push_back(a);
                exp_data_q.push_back(mem[a[DEPTH-1:0]]);
            end
        end
        clear_logs();
        @(posedge clk);
        #1;
        base = b; count = c; ram_length = len; start = 1'b1; expect_accept = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base  = $urandom;
        count = $urandom;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done, expected done", name);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_oe", ram_oe, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        reset = 1'b1;

        // Full-rate transfer: timing pinned by hand.
        ready_mode = 0;
        begin_xfer(5, 4, 1024);
        wait_done("t1");
        check("t1_beats", beat_data_q.size(), 4);
        for (int i = 0; i < 4 && i < beat_data_q.size(); i++) begin
            check("t1_data", beat_data_q[i], 105 + i);
            check("t1_beat_cycle", beat_cyc_q[i], start_cyc + 3 + i);
        end
        check("t1_done_cycle", done_cyc, start_cyc + 7);

        // Back-pressured transfer.
        ready_mode = 1;
        begin_xfer(5, 4, 1024);
        wait_done("t2");
        check("t2_beats", beat_data_q.size(), 4);
        for (int i = 0; i < 4 && i < beat_data_q.size(); i++) check("t2_data", beat_data_q[i], 105 + i);

        // Address wrap at RAM length.
        ready_mode = 0;
        begin_xfer(1022, 4, 1024);
        wait_done("t3");
        check("t3_reads", addr_log_q.size(), 4);
        check("t3_beats", beat_data_q.size(), 4);
        if (addr_log_q.size() == 4 && beat_data_q.size() == 4) begin
            check("t3_addr0", addr_log_q[0], 1022);
            check("t3_addr1", addr_log_q[1], 1023);
            check("t3_addr2", addr_log_q[2], 0);
            check("t3_addr3", addr_log_q[3], 1);
            check("t3_data0", beat_data_q[0], 1122);
            check("t3_data1", beat_data_q[1], 1123);
            check("t3_data2", beat_data_q[2], 100);
            check("t3_data3", beat_data_q[3], 101);
        end

        // Zero-length transfer.
        begin_xfer(7, 0, 1024);
        wait_done("t4");
        check("t4_done_cnt", done_cnt, 1);
        check("t4_err", done_err, 0);
        check("t4_reads", oe_cnt, 0);
        check("t4_valids", valid_cnt, 0);

        // Base beyond the RAM.
        begin_xfer(2000, 3, 1024);
        wait_done("t5");
        check("t5_done_cnt", done_cnt, 1);
        check("t5_err", done_err, 1);
        check("t5_reads", oe_cnt, 0);
        check("t5_valids", valid_cnt, 0);

        // Reset mid-transfer with one word buffered.
        ready_mode = 2;
        begin_xfer(10, 8, 1024);
        begin
            int t = 0;
            while (!m_valid && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            check("t6_first_buffered", m_valid, 1);
        end
        reset = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        outstanding   = 0;
        expect_accept = 1'b0;
        #1;
        check("t6_rst_m_valid", m_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ram_oe", ram_oe, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ready_mode = 0;
        begin_xfer(0, 2, 1024);
        wait_done("t6");
        check("t6_beats", beat_data_q.size(), 2);
        if (beat_data_q.size() == 2) begin
            check("t6_data0", beat_data_q[0], 100);
            check("t6_data1", beat_data_q[1], 101);
        end

        // Start pulsed while busy must be ignored.
        ready_mode = 1;
        begin_xfer(20, 5, 1024);
        repeat (2) @(posedge clk);
        #1;
        check("t7_busy_before_pulse", busy, 1);
        base = 0; count = 1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t7");
        repeat (5) @(posedge clk);
        #1;
        check("t7_done_cnt", done_cnt, 1);
        check("t7_reads", oe_cnt, 5);
        check("t7_beats", beat_data_q.size(), 5);
        for (int i = 0; i < 5 && i < beat_data_q.size(); i++) check("t7_data", beat_data_q[i], 120 + i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
